iommu_tlb: RTL
==============

Name: iommu_tlb

Overview:
Fully-associative translation cache for the IOMMU, 4 KB page granularity. Answers IOMMU lookups combinationally in the same cycle. Accepts fill updates after page-table walks, plus page-invalidate and flush-all maintenance commands from the control plane. Keeps hit/miss counters for performance monitoring.

Parameters:
ENTRIES, 8, number of TLB entries; power of two, 2..32
IDX_W, $clog2(ENTRIES), entry index / victim pointer width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
query_valid  input  1  lookup strobe from IOMMU
query_vaddr  input  32  device virtual address to translate
hit  output  1  combinational: query_valid and a valid entry's tag equals query_vaddr[31:12]
paddr  output  32  combinational: {matching PPN, query_vaddr[11:0]}; 0 when hit=0
update_valid  input  1  fill strobe, one cycle
update_vaddr  input  32  VPN source is [31:12]; [11:0] ignored
update_paddr  input  32  PPN source is [31:12]; [11:0] ignored
inv_valid  input  1  invalidate the single page inv_vaddr[31:12]
inv_vaddr  input  32  page to invalidate
flush  input  1  invalidate all entries
hit_count  output  32  lookups that hit
miss_count  output  32  lookups that missed
valid_count  output  IDX_W+1  number of currently valid entries

Behaviour:
- Reset (reset=0, asynchronous):
  - all valid bits 0; victim pointer 0.
  - hit_count, miss_count, valid_count 0.
  - hit 0, paddr 0.
  - Tag/PPN storage need not be reset.
- Entry contents: valid, vpn[19:0], ppn[19:0].
- Lookup:
  - purely combinational, zero latency; hit and paddr are stable the same cycle query_vaddr is held.
  - With query_valid=0: hit=0, paddr=0.
  - At most one entry can match; no-duplicate rule enforced on fill.
- Counters: on each clock edge with query_valid=1, increment hit_count if hit else miss_count. Both saturate at 32'hFFFFFFFF.
- Fill (update_valid=1), victim selection:
  - If a valid entry already holds the VPN, overwrite its PPN in place; pointer unchanged.
  - Else the lowest-index invalid entry; pointer unchanged.
  - Else entry[victim pointer]; pointer increments mod ENTRIES.
  - The written entry becomes valid with the new VPN and PPN.
- Invalidate (inv_valid=1): clear valid on the entry matching inv_vaddr[31:12]. No match -> no effect.
- Flush (flush=1): clear all valid bits in one cycle; pointer returns to 0.
- Same-cycle priority:
  - flush > inv > update; flush drops a simultaneous update and inv.
  - inv and update on the same VPN -> entry ends invalid.
  - inv and update on different VPNs -> both take effect. The fill's victim choice uses pre-edge valid bits, so an entry freed by the same-cycle inv is not reused that cycle.
- Write-then-read:
  - A query in the same cycle as an update/inv/flush sees pre-edge contents.
  - The new state is visible to queries from the next cycle.
  - The counter increment uses the pre-edge hit result.
- valid_count: registered popcount of the valid bits, updated on the same edge as the valid bits.
- Reset asserted mid-operation: all state clears immediately. The first edge after deassertion behaves as from reset.
- Timing contract with IOMMU:
  - the IOMMU holds query_valid for exactly one cycle and samples hit and paddr at the end of that cycle;
  - the IOMMU issues update_valid one cycle after its page-table walk completes.

Test Plan:
1. Reset, then query 0x0040_1ABC -> hit=0, paddr=0; after edge miss_count=1, hit_count=0.
2. Update vaddr 0x0040_1000 / paddr 0x1234_5000; next cycle query 0x0040_1ABC -> hit=1, paddr=0x1234_5ABC; hit_count=1; valid_count=1.
3. Fill ENTRIES+2 distinct VPNs 0x1..0xA with ENTRIES=8:
   - entries 0..7 fill in order;
   - VPN 0x9 replaces entry 0, VPN 0xA replaces entry 1;
   - querying VPN 0x1 and 0x2 misses, VPN 0x3 hits;
   - valid_count=8.
4. Re-update an existing VPN 0x3 with new PPN 0xBEEF0 -> same entry overwritten, valid_count unchanged, query returns 0xBEEF_0xxx.
5. Same-cycle inv and update on VPN 0x5 -> next-cycle query of VPN 0x5 misses. Then inv of a non-resident page -> no change.
6. Flush with a simultaneous update -> valid_count=0, all queries miss, victim pointer 0. Async reset pulse mid-fill -> counters read 0 before the next clock edge.

Source files
------------

// File: rtl/iommu_tlb.sv
// Fully-associative IOMMU translation cache with 4 KB pages. Lookup is combinational;
// fills, single-page invalidates and flushes update the entries on the clock edge.
module iommu_tlb #(
   parameter int ENTRIES = 8,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             query_valid,
   input  logic [31:0]      query_vaddr,
   output logic             hit,
   output logic [31:0]      paddr,
   input  logic             update_valid,
   input  logic [31:0]      update_vaddr,
   input  logic [31:0]      update_paddr,
   input  logic             inv_valid,
   input  logic [31:0]      inv_vaddr,
   input  logic             flush,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count,
   output logic [IDX_W:0]   valid_count
);

   localparam logic [31:0] CNT_MAX = '1;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [19:0]        vpn_q [ENTRIES];
   logic [19:0]        ppn_q [ENTRIES];
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [31:0]        hit_cnt_q, hit_cnt_d;
   logic [31:0]        miss_cnt_q, miss_cnt_d;
   logic [IDX_W:0]     vcnt_q, vcnt_d;

   logic [19:0]        upd_vpn, inv_vpn;
   logic               upd_hit, free_found, wr_en;
   logic [IDX_W-1:0]   upd_hit_idx, free_idx, wr_idx;

   assign upd_vpn = update_vaddr[31:12];
   assign inv_vpn = inv_vaddr[31:12];

   // At most one entry can match because fills never create duplicate VPNs.
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first, so no path leaves it unassigned (no latch).
      hit   = 1'b0;
      paddr = '0;
      if (query_valid) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && vpn_q[i] == query_vaddr[31:12]) begin
               hit   = 1'b1;
               paddr = {ppn_q[i], query_vaddr[11:0]};
            end
         end
      end
   end

   // Descending scan so the lowest matching / lowest free index wins.
   always_comb begin
      upd_hit     = 1'b0;
      upd_hit_idx = '0;
      free_found  = 1'b0;
      free_idx    = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && vpn_q[i] == upd_vpn) begin
            upd_hit     = 1'b1;
            upd_hit_idx = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Invalidate clears pre-edge matches first; the fill then sets its own entry,
   // unless it targets the very page being invalidated.
   always_comb begin
      valid_d = valid_q;
      ptr_d   = ptr_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      if (flush) begin
         valid_d = '0;
         ptr_d   = '0;
      end else begin
         if (inv_valid) begin
            for (int i = 0; i < ENTRIES; i++) begin
               if (valid_q[i] && vpn_q[i] == inv_vpn) valid_d[i] = 1'b0;
            end
         end
         if (update_valid) begin
            wr_en = 1'b1;
            if (upd_hit) begin
               wr_idx = upd_hit_idx;
            end else if (free_found) begin
               wr_idx = free_idx;
            end else begin
               wr_idx = ptr_q;
               ptr_d  = ptr_q + IDX_W'(1);
            end
            valid_d[wr_idx] = !(inv_valid && inv_vpn == upd_vpn);
         end
      end
   end

   always_comb begin
      vcnt_d = '0;
      for (int i = 0; i < ENTRIES; i++) vcnt_d = vcnt_d + (IDX_W+1)'(valid_d[i]);
   end

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (query_valid) begin
         if (hit) begin
            if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + 32'd1;
         end else begin
            if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + 32'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q    <= '0;
         ptr_q      <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         vcnt_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         ptr_q      <= ptr_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         vcnt_q     <= vcnt_d;
      end
   end

   // NOTE: tag/PPN storage has no reset; the valid bits alone decide whether an entry is usable.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         vpn_q[wr_idx] <= upd_vpn;
         ppn_q[wr_idx] <= update_paddr[31:12];
      end
   end

   assign hit_count   = hit_cnt_q;
   assign miss_count  = miss_cnt_q;
   assign valid_count = vcnt_q;

endmodule
